// File: rtl/combo_logic_pipe_if.sv
// Handshake and data bundle between the stimulus/port layer and combo_logic_pipe.
interface combo_logic_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [2:0]       control_in;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] acc_out;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, a_in, b_in, control_in, acc_clr, out_ready,
        input  in_ready, out_valid, result, carry, zero, overflow, acc_out
    );

    // Pipeline side
    modport slave (
        input  in_valid, a_in, b_in, control_in, acc_clr, out_ready,
        output in_ready, out_valid, result, carry, zero, overflow, acc_out
    );
endinterface

// File: rtl/combo_logic_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, flags and a persistent
// accumulator. S1 holds the accepted operands, S2 holds the computed result.
module combo_logic_pipe #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    combo_logic_pipe_if.slave bus
);
    localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_ACC = 3'b111
    } op_e;

    // Stage 1: captured bundle
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;

    // Stage 2: result and flags
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    // Accumulator
    logic [WIDTH-1:0] acc_q, acc_d;

    // Handshake / datapath intermediates
    logic             s1_en;
    logic             s2_en;
    logic             move;
    logic [WIDTH:0]   alu_w;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_base;
    logic             alu_c;
    logic             alu_v;

    // Stage enables: a stage advances when empty or when its successor advances
    always_comb begin
        s2_en = !s2_valid_q || bus.out_ready;
        s1_en = !s1_valid_q || s2_en;
        move  = s1_valid_q && s2_en;
    end

    // Combinational ALU on the S1 bundle; clear takes priority over the old accumulator
    always_comb begin
        acc_base = bus.acc_clr ? '0 : acc_q;
        alu_w    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                alu_w = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                alu_c = alu_w[WIDTH];
                alu_v = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                        (alu_w[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_w = {1'b0, s1_a_q} - {1'b0, s1_b_q};
                alu_c = alu_w[WIDTH];
                alu_v = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                        (alu_w[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_AND: alu_w = {1'b0, s1_a_q & s1_b_q};
            OP_OR:  alu_w = {1'b0, s1_a_q | s1_b_q};
            OP_XOR: alu_w = {1'b0, s1_a_q ^ s1_b_q};
            OP_SHL: alu_w = {1'b0, s1_a_q << s1_b_q[SH_W-1:0]};
            OP_SHR: alu_w = {1'b0, s1_a_q >> s1_b_q[SH_W-1:0]};
            OP_ACC: begin
                alu_w = {1'b0, acc_base} + {1'b0, s1_a_q};
                alu_c = alu_w[WIDTH];
                alu_v = (acc_base[WIDTH-1] == s1_a_q[WIDTH-1]) &&
                        (alu_w[WIDTH-1] != acc_base[WIDTH-1]);
            end
            default: alu_w = '0;
        endcase
        alu_res = alu_w[WIDTH-1:0];
    end

    // Next-state for both stages and the accumulator; data only loads on a real transfer
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        acc_d      = acc_q;

        if (s1_en) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d  = bus.a_in;
                s1_b_d  = bus.b_in;
                s1_op_d = op_e'(bus.control_in);
            end
        end

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
        end

        if (move) begin
            res_d   = alu_res;
            carry_d = alu_c;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_v;
        end

        // An ACC moving into S2 already folded the clear into acc_base
        if (move && (s1_op_q == OP_ACC)) begin
            acc_d = alu_res;
        end else if (bus.acc_clr) begin
            acc_d = '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            acc_q      <= acc_d;
        end
    end

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = s2_valid_q;
    assign bus.result    = res_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.acc_out   = acc_q;
endmodule

// File: tb/tb_combo_logic_pipe.sv
// Self-checking bench for combo_logic_pipe: directed literal cases plus
// randomized traffic against a transaction-level reference model.
module tb_combo_logic_pipe;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;

    combo_logic_pipe_if #(.WIDTH(WIDTH)) bus ();

    combo_logic_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int z;
        int v;
        int acc;
    } exp_t;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];
    int   model_acc;
    bit   clr_tag;
    bit   hold_pending;
    int   hold_r, hold_c, hold_z, hold_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference: plain integer arithmetic on 8-bit values
    function automatic exp_t model_op(input int op, input int a, input int b,
                                      input bit clr, inout int acc);
        exp_t e;
        int   s;
        int   sv;
        int   base;
        e.c = 0;
        e.v = 0;
        case (op)
            0: begin s = a + b; e.r = s % 256; e.c = int'(s > 255);
                     sv = sx(a) + sx(b); e.v = int'(sv > 127 || sv < -128); end
            1: begin s = a - b; e.r = (s + 256) % 256; e.c = int'(a < b);
                     sv = sx(a) - sx(b); e.v = int'(sv > 127 || sv < -128); end
            2: e.r = a & b;
            3: e.r = a | b;
            4: e.r = a ^ b;
            5: e.r = (a * (1 << (b % 8))) % 256;
            6: e.r = a / (1 << (b % 8));
            default: begin
                base = clr ? 0 : acc;
                s = base + a; e.r = s % 256; e.c = int'(s > 255);
                sv = sx(base) + sx(a); e.v = int'(sv > 127 || sv < -128);
                acc = e.r;
            end
        endcase
        e.z = int'(e.r == 0);
        e.acc = acc;
        return e;
    endfunction

    // Monitor: checks outputs against the model on every meaningful cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_acc = 0;
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    check("hold_valid", 32'(bus.out_valid), 32'd1);
                    check("hold_result", 32'(bus.result), 32'(hold_r));
                    check("hold_flags", {29'd0, bus.carry, bus.zero, bus.overflow},
                          32'(hold_c * 4 + hold_z * 2 + hold_v));
                end
                hold_pending = 1'b0;
                if (bus.out_valid && !bus.out_ready) begin
                    hold_pending = 1'b1;
                    hold_r = int'(bus.result);
                    hold_c = int'(bus.carry);
                    hold_z = int'(bus.zero);
                    hold_v = int'(bus.overflow);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 32'(bus.out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 32'(bus.result), 32'(e.r));
                        check("carry", 32'(bus.carry), 32'(e.c));
                        check("zero", 32'(bus.zero), 32'(e.z));
                        check("overflow", 32'(bus.overflow), 32'(e.v));
                        check("acc_out", 32'(bus.acc_out), 32'(e.acc));
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(model_op(int'(bus.control_in), int'(bus.a_in),
                                             int'(bus.b_in), clr_tag, model_acc));
                end else if (bus.acc_clr && !clr_tag) begin
                    model_acc = 0;
                end
            end
        end
    end

    // One bundle into an idle pipe; checks 2-cycle latency and literal outputs
    task automatic single(input int op, input int a, input int b, input bit clr,
                          input int er, input int ec, input int ez, input int ev,
                          input string name);
        int n;
        bit got;
        @(posedge clk); #1;
        bus.in_valid   = 1'b1;
        bus.control_in = 3'(op);
        bus.a_in       = 8'(a);
        bus.b_in       = 8'(b);
        bus.acc_clr    = clr;
        clr_tag        = clr;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin got = 1'b1; break; end
        end
        check({name, "_accept"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a_in     = 8'($urandom);
        bus.b_in     = 8'($urandom);
        @(negedge clk);
        check({name, "_early"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.acc_clr = 1'b0;
        clr_tag     = 1'b0;
        n = 1;
        got = 1'b0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.out_valid) begin got = 1'b1; break; end
        end
        check({name, "_latency"}, 32'(n), 32'd2);
        check({name, "_res"}, 32'(bus.result), 32'(er));
        check({name, "_flags"}, {29'd0, bus.carry, bus.zero, bus.overflow},
              32'(ec * 4 + ez * 2 + ev));
    endtask

    initial begin
        int  accepts;
        int  sent;
        bit  took;
        vectors      = 0;
        miscompares  = 0;
        model_acc    = 0;
        clr_tag      = 1'b0;
        hold_pending = 1'b0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.a_in       = '0;
        bus.b_in       = '0;
        bus.control_in = '0;
        bus.acc_clr    = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_acc", 32'(bus.acc_out), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", {29'd0, bus.carry, bus.zero, bus.overflow}, 32'd0);

        single(0, 'hF0, 'h20, 0, 'h10, 1, 0, 0, "add_f0_20");
        single(1, 'h80, 'h01, 0, 'h7F, 0, 0, 1, "sub_80_01");
        single(1, 5, 5, 0, 0, 0, 1, 0, "sub_5_5");
        single(5, 'h81, 'h09, 0, 'h02, 0, 0, 0, "shl_81_9");
        single(6, 'h80, 3, 0, 'h10, 0, 0, 0, "shr_80_3");
        single(7, 3, 0, 0, 3, 0, 0, 0, "acc_3");
        check("acc_after_3", 32'(bus.acc_out), 32'd3);
        single(7, 4, 0, 0, 7, 0, 0, 0, "acc_4");
        check("acc_after_4", 32'(bus.acc_out), 32'd7);
        single(7, 9, 0, 1, 9, 0, 0, 0, "acc_clr_9");
        check("acc_after_clr9", 32'(bus.acc_out), 32'd9);

        // Six back-to-back ADDs against a stalled consumer
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        accepts = 0;
        sent = 0;
        bus.in_valid = 1'b1; bus.control_in = 3'd0;
        bus.a_in = 8'(10); bus.b_in = 8'(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (took) begin
                accepts++; sent++;
                bus.a_in = 8'(10 + sent * 16); bus.b_in = 8'(sent);
            end
        end
        check("bp_accepts", 32'(accepts), 32'd2);
        @(negedge clk);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && sent < 6; i++) begin
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (took) begin
                sent++;
                bus.a_in = 8'(10 + sent * 16); bus.b_in = 8'(sent);
            end
            if (sent == 6) bus.in_valid = 1'b0;
        end
        check("bp_sent", 32'(sent), 32'd6);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset with both stages full
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.control_in = 3'd7;
        bus.a_in = 8'(5); bus.b_in = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_acc", 32'(bus.acc_out), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_result", 32'(bus.result), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", 32'(bus.out_valid), 32'd0);
        end

        // Randomized traffic; clears only issued with the pipe empty
        for (int unsigned cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(9) < 7);
            bus.acc_clr = 1'b0;
            if (!bus.in_valid || took) begin
                if ($urandom_range(3) != 0) begin
                    bus.in_valid   = 1'b1;
                    bus.control_in = ($urandom_range(2) == 0) ? 3'd7 : 3'($urandom);
                    bus.a_in       = 8'($urandom);
                    bus.b_in       = 8'($urandom);
                end else begin
                    bus.in_valid   = 1'b0;
                    bus.control_in = 3'($urandom);
                    bus.a_in       = 8'($urandom);
                    bus.b_in       = 8'($urandom);
                    if (exp_q.size() == 0 && $urandom_range(2) == 0) bus.acc_clr = 1'b1;
                end
            end
        end
        @(negedge clk);
        took = bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        if (took) bus.in_valid = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && bus.in_valid; i++) begin
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (took) bus.in_valid = 1'b0;
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
